bck_issue_scheduler: RTL and testbench
======================================

// Module: bck_issue_scheduler
// PURPOSE
//  Sequences the backward-extension pipeline (stage-1 control onward). Holds up to NUM_SLOTS reads that left forward
//  extension. Issues one token per cycle: BCK_INI for a newly loaded read, BCK_RUN for a read whose previous token
//  has returned, BUBBLE otherwise. Each slot has at most one token in flight. Slots are shared round-robin. The
//  issuing slot is freed when the pipeline reports last_one_read.
// PARAMETERS
//  NUM_SLOTS       4  reads resident at once (power of 2, 2..16)
//  READ_NUM_WIDTH  9  read id width
//  SLOT_W          $clog2(NUM_SLOTS)  slot index width (derived, localparam)
// PORTS
//  clk                 in   1    clock
//  rst                 in   1    synchronous reset, active-low (rst==0 resets)
//  stall               in   1    pipeline stall; freezes issue outputs
//  load_valid          in   1    new read offered by the forward stage
//  load_ready          out  1    at least one EMPTY slot (combinational from slot state)
//  load_read_num       in   RNW  read id
//  load_forward_size_n in   7    forward result count
//  load_min_intv       in   7    minimum interval
//  load_backward_x     in   7    backward start position
//  issue_status        out  6    BCK_INI / BCK_RUN / BUBBLE (one-hot encoding, see package)
//  issue_slot          out  SLOT_W  slot of the issued token
//  issue_read_num      out  RNW  read id of the token
//  issue_forward_size_n out 7    slot copy
//  issue_min_intv      out  7    slot copy
//  issue_backward_x    out  7    slot copy
//  ret_valid           in   1    token returned from the pipeline tail
//  ret_slot            in   SLOT_W  slot of the returned token
//  ret_last            in   1    returned token carried last_one_read=1
//  done_valid          out  1    one-cycle pulse: read finished
//  done_read_num       out  RNW  id of the finished read
//  busy                out  1    any slot not EMPTY
//  err                 out  1    sticky: ret_valid for a slot not in WAIT
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): all slots EMPTY; rr_ptr=0.
//    issue_status=BUBBLE; every other issue_* output=0; done_valid=0; done_read_num=0; err=0.
//  - Slot states: EMPTY -> LOADED on load accept -> WAIT when INI is issued -> READY on a ret with ret_last=0.
//    READY -> WAIT when RUN is issued. WAIT -> EMPTY on a ret with ret_last=1.
//  - Load: accepted at an edge where load_valid&&load_ready. Fields go into the lowest-index EMPTY slot.
//    A slot freed at the same edge is not visible to load until the next cycle.
//  - Issue: at each edge with stall==0, the arbiter grants the first slot in LOADED or READY at or after rr_ptr
//    (wrapping modulo NUM_SLOTS).
//    On a grant: the registered issue_* outputs take that slot's fields, status is INI if LOADED and RUN if READY,
//    the slot goes to WAIT, and rr_ptr=grant+1 (wrapping).
//    With no eligible slot: issue_status=BUBBLE and issue fields=0.
//  - Latency: load accepted at edge t -> earliest INI visible after edge t+1. Ret at edge t -> earliest RUN after edge t+1.
//  - Stall==1: all issue_* outputs hold; no grant; rr_ptr holds. Load and ret are still processed.
//  - Ret: processed every edge. If the slot is not in WAIT, the slot is unchanged and err is set (sticky until reset).
//    ret_last=1 -> slot EMPTY; done_valid=1 and done_read_num=slot id for exactly one cycle after the edge.
//  - Simultaneous events: a ret (WAIT->READY) and a grant at the same edge cannot hit the same slot, because the
//    grant uses pre-edge state. A load and a ret_last on different slots in one edge are both honoured.
//  - Reset mid-operation discards all slots. The pipeline is reset together with this block; a stale ret after
//    reset sets err.
// STRUCTURE
//  - Shared package smem_pkg: BCK_INI=6'b00_1000, BCK_RUN=6'b01_0000, BUBBLE=6'b00_0000 (with F_init/F_run/F_break/
//    BCK_END); slot-state enum {S_EMPTY,S_LOADED,S_WAIT,S_READY}; READ_NUM_WIDTH.
//  - Sub-module rr_arbiter #(N): combinational, inputs req[N] and ptr, outputs gnt_valid and gnt_idx.
//    Slot arrays, the load priority encoder and the output registers live in this block.
// TESTING
//  1. Reset, then load id 5 (fsn=7, mi=1, bx=10), ret_valid=0 -> INI slot0 id5 one cycle later, then BUBBLEs; busy=1.
//  2. Load ids 1..4 back to back; return each token 3 cycles after issue with ret_last=0 ->
//     INI order slots 0,1,2,3, then RUN order 0,1,2,3; load_ready=0 while 4 are resident.
//  3. Hold stall=1 for 5 cycles while slots are READY -> issue_* outputs frozen; RUN resumes the cycle after release
//     at the same rr_ptr.
//  4. ret_last=1 on slot2 (id 9) at the same edge as load_valid id 12 with all other slots full ->
//     done_valid pulse with id 9; load_ready goes 1 next cycle; id 12 lands in slot2 one cycle later.
//  5. ret_valid on an EMPTY slot -> err=1 and stays 1; slot states unchanged.
//  6. Assert rst=0 mid-run with 3 slots WAIT -> next cycle busy=0, BUBBLE, rr_ptr=0, done_valid=0.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared definitions for the backward-extension pipeline: token status codes,
// the per-slot lifecycle enum and the default read-id width.
package smem_pkg;

  localparam int READ_NUM_WIDTH = 9;

  // One-hot token status codes carried down the extension pipeline.
  localparam logic [5:0] BUBBLE  = 6'b00_0000;
  localparam logic [5:0] F_init  = 6'b00_0001;
  localparam logic [5:0] F_run   = 6'b00_0010;
  localparam logic [5:0] F_break = 6'b00_0100;
  localparam logic [5:0] BCK_INI = 6'b00_1000;
  localparam logic [5:0] BCK_RUN = 6'b01_0000;
  localparam logic [5:0] BCK_END = 6'b10_0000;

  // Lifecycle of one resident read.
  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_LOADED = 2'd1,
    S_WAIT   = 2'd2,
    S_READY  = 2'd3
  } slot_state_e;

endpackage

// File: rtl/bck_issue_scheduler_if.sv
// Bundle of the load, issue, return and completion signals of the
// backward-extension issue scheduler.
//
// Handshake semantics: the load channel is a valid/ready pair; a read is
// transferred at a rising clk edge where load_valid && load_ready, and
// load_valid must stay high with stable fields until that edge. load_ready
// depends only on slot state, never on load_valid. The issue, ret and done
// channels are qualifier-only: issue_status != BUBBLE, ret_valid and
// done_valid mark a transfer at the edge, and there is no back-pressure on
// them other than stall freezing the issue registers.
interface bck_issue_scheduler_if #(
  parameter int NUM_SLOTS      = 4,
  parameter int READ_NUM_WIDTH = 9
);
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic                      stall;
  logic                      load_valid;
  logic                      load_ready;
  logic [READ_NUM_WIDTH-1:0] load_read_num;
  logic [6:0]                load_forward_size_n;
  logic [6:0]                load_min_intv;
  logic [6:0]                load_backward_x;
  logic [5:0]                issue_status;
  logic [SLOT_W-1:0]         issue_slot;
  logic [READ_NUM_WIDTH-1:0] issue_read_num;
  logic [6:0]                issue_forward_size_n;
  logic [6:0]                issue_min_intv;
  logic [6:0]                issue_backward_x;
  logic                      ret_valid;
  logic [SLOT_W-1:0]         ret_slot;
  logic                      ret_last;
  logic                      done_valid;
  logic [READ_NUM_WIDTH-1:0] done_read_num;
  logic                      busy;
  logic                      err;

  // Environment side: forward stage, pipeline tail and stall source.
  modport master (
    output stall, load_valid, load_read_num, load_forward_size_n,
           load_min_intv, load_backward_x, ret_valid, ret_slot, ret_last,
    input  load_ready, issue_status, issue_slot, issue_read_num,
           issue_forward_size_n, issue_min_intv, issue_backward_x,
           done_valid, done_read_num, busy, err
  );

  // Scheduler side.
  modport slave (
    input  stall, load_valid, load_read_num, load_forward_size_n,
           load_min_intv, load_backward_x, ret_valid, ret_slot, ret_last,
    output load_ready, issue_status, issue_slot, issue_read_num,
           issue_forward_size_n, issue_min_intv, issue_backward_x,
           done_valid, done_read_num, busy, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping modulo N (N is a power of two so the index simply wraps).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);
  localparam int W = $clog2(N);

  logic [W-1:0] idx;

  // Scan offsets from the far end down so the nearest requester wins last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_i + W'(k);
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/bck_issue_scheduler.sv
// Backward-extension issue scheduler: keeps up to NUM_SLOTS resident reads,
// issues one INI/RUN/BUBBLE token per cycle with round-robin fairness and at
// most one token in flight per slot, and retires a read on its last return.
module bck_issue_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int READ_NUM_WIDTH = smem_pkg::READ_NUM_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  bck_issue_scheduler_if.slave          sched_if,
  output logic [2*NUM_SLOTS-1:0]        dbg_slot_state_o,
  output logic [$clog2(NUM_SLOTS)-1:0]  dbg_rr_ptr_o
);
  import smem_pkg::*;

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  slot_state_e               state_q [NUM_SLOTS];
  slot_state_e               state_d [NUM_SLOTS];
  logic [READ_NUM_WIDTH-1:0] rn_q    [NUM_SLOTS];
  logic [6:0]                fsn_q   [NUM_SLOTS];
  logic [6:0]                mi_q    [NUM_SLOTS];
  logic [6:0]                bx_q    [NUM_SLOTS];
  logic [SLOT_W-1:0]         rr_ptr_q;

  logic [5:0]                issue_status_q;
  logic [SLOT_W-1:0]         issue_slot_q;
  logic [READ_NUM_WIDTH-1:0] issue_rn_q;
  logic [6:0]                issue_fsn_q;
  logic [6:0]                issue_mi_q;
  logic [6:0]                issue_bx_q;
  logic                      done_valid_q;
  logic [READ_NUM_WIDTH-1:0] done_rn_q;
  logic                      err_q;

  logic [NUM_SLOTS-1:0]      empty_vec;
  logic [NUM_SLOTS-1:0]      req_vec;
  logic                      gnt_valid;
  logic [SLOT_W-1:0]         gnt_idx;
  logic                      load_found;
  logic [SLOT_W-1:0]         load_idx;
  logic                      load_fire;
  logic                      grant_fire;
  logic                      ret_in_wait;
  logic                      ret_done;

  // Per-slot status vectors and debug view of the slot states.
  always_comb begin
    empty_vec        = '0;
    req_vec          = '0;
    dbg_slot_state_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      empty_vec[i] = (state_q[i] == S_EMPTY);
      req_vec[i]   = (state_q[i] == S_LOADED) || (state_q[i] == S_READY);
      dbg_slot_state_o[2*i +: 2] = state_q[i];
    end
  end

  // Load target: lowest-index EMPTY slot, judged on pre-edge state so a slot
  // freed at this edge only becomes loadable next cycle.
  always_comb begin
    load_found = 1'b0;
    load_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (empty_vec[i]) begin
        load_found = 1'b1;
        load_idx   = SLOT_W'(i);
      end
    end
  end

  rr_arbiter #(.N(NUM_SLOTS)) u_arb (
    .req_i       (req_vec),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign load_fire   = sched_if.load_valid && load_found;
  assign grant_fire  = !sched_if.stall && gnt_valid;
  assign ret_in_wait = sched_if.ret_valid && (state_q[sched_if.ret_slot] == S_WAIT);
  assign ret_done    = ret_in_wait && sched_if.ret_last;

  // Slot transitions. Load hits an EMPTY slot, grant a LOADED/READY slot and a
  // legal ret a WAIT slot, so at most one of them touches any given slot.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) state_d[i] = state_q[i];
    if (grant_fire)  state_d[gnt_idx] = S_WAIT;
    if (ret_in_wait) state_d[sched_if.ret_slot] = sched_if.ret_last ? S_EMPTY : S_READY;
    if (load_fire)   state_d[load_idx] = S_LOADED;
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= S_EMPTY;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= state_d[i];
    end
  end

  // Slot payload capture on load accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        rn_q[i]  <= '0;
        fsn_q[i] <= '0;
        mi_q[i]  <= '0;
        bx_q[i]  <= '0;
      end
    end else if (load_fire) begin
      rn_q[load_idx]  <= sched_if.load_read_num;
      fsn_q[load_idx] <= sched_if.load_forward_size_n;
      mi_q[load_idx]  <= sched_if.load_min_intv;
      bx_q[load_idx]  <= sched_if.load_backward_x;
    end
  end

  // Registered issue token and round-robin pointer; both hold during stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_status_q <= BUBBLE;
      issue_slot_q   <= '0;
      issue_rn_q     <= '0;
      issue_fsn_q    <= '0;
      issue_mi_q     <= '0;
      issue_bx_q     <= '0;
      rr_ptr_q       <= '0;
    end else if (!sched_if.stall) begin
      if (gnt_valid) begin
        issue_status_q <= (state_q[gnt_idx] == S_LOADED) ? BCK_INI : BCK_RUN;
        issue_slot_q   <= gnt_idx;
        issue_rn_q     <= rn_q[gnt_idx];
        issue_fsn_q    <= fsn_q[gnt_idx];
        issue_mi_q     <= mi_q[gnt_idx];
        issue_bx_q     <= bx_q[gnt_idx];
        rr_ptr_q       <= gnt_idx + SLOT_W'(1);
      end else begin
        issue_status_q <= BUBBLE;
        issue_slot_q   <= '0;
        issue_rn_q     <= '0;
        issue_fsn_q    <= '0;
        issue_mi_q     <= '0;
        issue_bx_q     <= '0;
      end
    end
  end

  // Completion pulse and sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_valid_q <= 1'b0;
      done_rn_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      done_valid_q <= ret_done;
      done_rn_q    <= ret_done ? rn_q[sched_if.ret_slot] : '0;
      if (sched_if.ret_valid && !ret_in_wait) err_q <= 1'b1;
    end
  end

  assign sched_if.load_ready           = |empty_vec;
  assign sched_if.busy                 = ~&empty_vec;
  assign sched_if.issue_status         = issue_status_q;
  assign sched_if.issue_slot           = issue_slot_q;
  assign sched_if.issue_read_num       = issue_rn_q;
  assign sched_if.issue_forward_size_n = issue_fsn_q;
  assign sched_if.issue_min_intv       = issue_mi_q;
  assign sched_if.issue_backward_x     = issue_bx_q;
  assign sched_if.done_valid           = done_valid_q;
  assign sched_if.done_read_num        = done_rn_q;
  assign sched_if.err                  = err_q;
  assign dbg_rr_ptr_o                  = rr_ptr_q;

endmodule

// File: tb/tb_bck_issue_scheduler.sv
// Directed bench for bck_issue_scheduler: load/issue ordering, return-driven
// RUN tokens, stall freeze, retire-and-reload, error flag and mid-run reset.
module tb_bck_issue_scheduler;
  import smem_pkg::*;

  localparam int NS  = 4;
  localparam int RNW = 9;
  localparam int W   = 38;

  logic          clk;
  logic          rst;
  logic [7:0]    dbg_state;
  logic [1:0]    dbg_ptr;
  logic [W-1:0]  exp_q[$];
  int            n_vec;
  int            n_err;
  int            ret_at[NS];

  bck_issue_scheduler_if #(.NUM_SLOTS(NS), .READ_NUM_WIDTH(RNW)) bus ();

  bck_issue_scheduler #(.NUM_SLOTS(NS), .READ_NUM_WIDTH(RNW)) dut (
    .clk              (clk),
    .rst              (rst),
    .sched_if         (bus.slave),
    .dbg_slot_state_o (dbg_state),
    .dbg_rr_ptr_o     (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stall               = 1'b0;
    bus.load_valid          = 1'b0;
    bus.load_read_num       = '0;
    bus.load_forward_size_n = '0;
    bus.load_min_intv       = '0;
    bus.load_backward_x     = '0;
    bus.ret_valid           = 1'b0;
    bus.ret_slot            = '0;
    bus.ret_last            = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic drive_load(input logic v, input int rn, input int f, input int m, input int b);
    bus.load_valid          = v;
    bus.load_read_num       = RNW'(rn);
    bus.load_forward_size_n = 7'(f);
    bus.load_min_intv       = 7'(m);
    bus.load_backward_x     = 7'(b);
  endtask

  task automatic drive_ret(input logic v, input int slot, input logic last);
    bus.ret_valid = v;
    bus.ret_slot  = 2'(slot);
    bus.ret_last  = last;
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [W-1:0] tok(input logic [5:0] st, input int sl, input int rn,
                                       input int f, input int m, input int b);
    return {st, 2'(sl), RNW'(rn), 7'(f), 7'(m), 7'(b)};
  endfunction

  function automatic logic [W-1:0] bus_tok();
    return {bus.issue_status, bus.issue_slot, bus.issue_read_num,
            bus.issue_forward_size_n, bus.issue_min_intv, bus.issue_backward_x};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] got;
    n_vec = 0;
    n_err = 0;

    // 1: reset state, single load -> INI one cycle later
    reset_dut();
    check_eq("rst_status", bus.issue_status, BUBBLE);
    check_eq("rst_tok", bus_tok(), '0);
    check_eq("rst_done", bus.done_valid, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ready", bus.load_ready, 1);
    check_eq("rst_ptr", dbg_ptr, 0);
    drive_load(1'b1, 5, 7, 1, 10);
    tick();
    drive_load(1'b0, 0, 0, 0, 0);
    check_eq("t1_no_early_ini", bus.issue_status, BUBBLE);
    check_eq("t1_busy", bus.busy, 1);
    check_eq("t1_loaded", dbg_state, 8'h01);
    tick();
    check_eq("t1_ini", bus_tok(), tok(BCK_INI, 0, 5, 7, 1, 10));
    tick();
    check_eq("t1_bubble", bus_tok(), '0);
    check_eq("t1_wait", dbg_state, 8'h02);
    check_eq("t1_busy2", bus.busy, 1);

    // 2: four back-to-back loads, INI returned 3 cycles after issue
    reset_dut();
    exp_q.delete();
    for (int i = 1; i <= 4; i++) exp_q.push_back(tok(BCK_INI, i - 1, i, i + 10, i + 20, i + 30));
    for (int i = 1; i <= 4; i++) exp_q.push_back(tok(BCK_RUN, i - 1, i, i + 10, i + 20, i + 30));
    for (int s = 0; s < NS; s++) ret_at[s] = -1;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive_load(1'b1, c + 1, c + 11, c + 21, c + 31);
      else       drive_load(1'b0, 0, 0, 0, 0);
      drive_ret(1'b0, 0, 1'b0);
      for (int s = 0; s < NS; s++) if (ret_at[s] == c) drive_ret(1'b1, s, 1'b0);
      if (c == 0) check_eq("t2_ready_empty", bus.load_ready, 1);
      tick();
      if (c == 3) check_eq("t2_ready_full", bus.load_ready, 0);
      if (bus.issue_status != BUBBLE) begin
        got = bus_tok();
        if (exp_q.size() == 0) check_eq("t2_extra_tok", got, '0);
        else check_eq("t2_tok", got, exp_q.pop_front());
        if (bus.issue_status == BCK_INI) ret_at[bus.issue_slot] = c + 3;
      end
    end
    drive_ret(1'b0, 0, 1'b0);
    check_eq("t2_tok_left", exp_q.size(), 0);

    // 3: stall for 5 cycles while slots return to READY
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_ret(k < 4, k, 1'b0);
      tick();
      check_eq("t3_frozen", bus_tok(), tok(BCK_RUN, 3, 4, 14, 24, 34));
      check_eq("t3_ptr_hold", dbg_ptr, 0);
    end
    drive_ret(1'b0, 0, 1'b0);
    check_eq("t3_all_ready", dbg_state, 8'hFF);
    bus.stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t3_resume", bus_tok(), tok(BCK_RUN, i, i + 1, i + 11, i + 21, i + 31));
    end

    // 4: retire slot2 while a load waits; reload lands in slot2
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_load(1'b1, 7 + k, k, k, k);
      else       drive_load(1'b0, 0, 0, 0, 0);
      tick();
    end
    check_eq("t4_all_wait", dbg_state, 8'hAA);
    drive_load(1'b1, 12, 12, 13, 14);
    drive_ret(1'b1, 2, 1'b1);
    tick();
    drive_ret(1'b0, 0, 1'b0);
    check_eq("t4_done", bus.done_valid, 1);
    check_eq("t4_done_id", bus.done_read_num, 9);
    check_eq("t4_ready_up", bus.load_ready, 1);
    check_eq("t4_freed", dbg_state, 8'h8A);
    tick();
    drive_load(1'b0, 0, 0, 0, 0);
    check_eq("t4_done_pulse", bus.done_valid, 0);
    check_eq("t4_reloaded", dbg_state, 8'h9A);
    check_eq("t4_ready_down", bus.load_ready, 0);
    tick();
    check_eq("t4_ini_s2", bus_tok(), tok(BCK_INI, 2, 12, 12, 13, 14));
    check_eq("t4_ptr", dbg_ptr, 3);

    // 5: ret on an EMPTY slot sets sticky err, slot states untouched
    drive_ret(1'b1, 3, 1'b1);
    tick();
    check_eq("t5_done_id", bus.done_read_num, 10);
    check_eq("t5_err_clear", bus.err, 0);
    drive_ret(1'b1, 3, 1'b0);
    tick();
    drive_ret(1'b0, 0, 1'b0);
    check_eq("t5_err_set", bus.err, 1);
    check_eq("t5_states", dbg_state, 8'h2A);
    check_eq("t5_no_done", bus.done_valid, 0);
    tick();
    tick();
    check_eq("t5_err_sticky", bus.err, 1);
    check_eq("t5_states2", dbg_state, 8'h2A);

    // 6: reset mid-run with 3 slots WAIT and a last-return at the same edge
    rst = 1'b0;
    drive_ret(1'b1, 0, 1'b1);
    tick();
    rst = 1'b1;
    drive_ret(1'b0, 0, 1'b0);
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_bubble", bus_tok(), '0);
    check_eq("t6_ptr", dbg_ptr, 0);
    check_eq("t6_done", bus.done_valid, 0);
    check_eq("t6_err", bus.err, 0);
    check_eq("t6_states", dbg_state, 8'h00);
    drive_ret(1'b1, 1, 1'b1);
    tick();
    drive_ret(1'b0, 0, 1'b0);
    check_eq("t6_stale_err", bus.err, 1);
    check_eq("t6_stale_done", bus.done_valid, 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
